// File: rtl/chroma_luma_gen_pkg.sv
// Shared constants and helpers for the chroma/luma generator:
// colour-RAM field map, DAC zero code, standard constants and the sine table.
package chroma_luma_gen_pkg;

    localparam int LUMA_MSB  = 17;
    localparam int LUMA_LSB  = 12;
    localparam int PHASE_MSB = 11;
    localparam int PHASE_LSB = 4;
    localparam int AMP_MSB   = 3;
    localparam int AMP_LSB   = 0;

    localparam logic [7:0] CHROMA_ZERO = 8'd128;

    // Increments for a 24-bit accumulator clocked at 14.31818 MHz (4x NTSC fsc).
    localparam logic [23:0] PHASE_INC_NTSC = 24'h400000;
    localparam logic [23:0] PHASE_INC_PAL  = 24'd5195058;

    localparam logic [7:0] BURST_PHASE_NTSC = 8'd128;
    localparam logic [7:0] BURST_PHASE_PAL  = 8'd96;

    typedef struct packed {
        logic valid;
        logic blank;
        logic burst;
        logic sync;
        logic pal_flip;
    } ctl_t;

    // round(127*sin(2*pi*k/256)) for k = 0..64; the rest follows by symmetry.
    localparam logic [6:0] QSINE [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    function automatic logic signed [7:0] sine_value(input logic [7:0] k);
        logic [6:0] m;
        logic [7:0] mirror;
        logic [6:0] q;
        m      = k[6:0];
        mirror = 8'd128 - {1'b0, m};
        if (m <= 7'd64) q = QSINE[m];
        else            q = QSINE[mirror[6:0]];
        if (k[7]) return -$signed({1'b0, q});
        else      return  $signed({1'b0, q});
    endfunction

endpackage

// File: rtl/chroma_luma_gen_if.sv
// Video-timing, colour-RAM port-B and DAC signals of the chroma/luma generator.
// master = timing/RAM/DAC side, slave = the generator.
interface chroma_luma_gen_if #(
    parameter int ACC_W = 24
);
    logic [ACC_W-1:0] phase_inc;
    logic             phase_sync;
    logic             in_valid;
    logic [3:0]       pixel_index;
    logic             blank;
    logic             burst;
    logic             sync;
    logic             pal_flip;
    logic [3:0]       lr_addr;
    logic [17:0]      lr_dout;
    logic [5:0]       luma;
    logic [7:0]       chroma;
    logic             out_valid;

    modport master (
        output phase_inc, phase_sync, in_valid, pixel_index,
               blank, burst, sync, pal_flip, lr_dout,
        input  lr_addr, luma, chroma, out_valid
    );

    modport slave (
        input  phase_inc, phase_sync, in_valid, pixel_index,
               blank, burst, sync, pal_flip, lr_dout,
        output lr_addr, luma, chroma, out_valid
    );
endinterface

// File: rtl/chroma_luma_gen_sine_rom.sv
// 256 x 8 signed sine ROM with registered output; forms the S3 pipeline register.
module chroma_luma_gen_sine_rom
    import chroma_luma_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        addr,
    output logic signed [7:0] data
);

    always_ff @(posedge clk) begin
        if (rst) data <= '0;
        else     data <= sine_value(addr);
    end

endmodule

// File: rtl/chroma_luma_gen.sv
// Colour index to luma/chroma DAC codes: NCO subcarrier, colour-RAM lookup,
// burst insertion and blanking/sync, 4-clk fixed latency.
module chroma_luma_gen
    import chroma_luma_gen_pkg::*;
#(
    parameter int         ACC_W       = 24,
    parameter logic [7:0] BURST_PHASE = BURST_PHASE_NTSC,
    parameter logic [3:0] BURST_AMP   = 4'd6
) (
    input logic               clk,
    input logic               rst,
    chroma_luma_gen_if.slave  bus
);

    logic [ACC_W-1:0] acc;

    ctl_t             ctl_in;
    ctl_t             s0_ctl;
    ctl_t             s1_ctl;
    logic [7:0]       s0_phase;
    logic [7:0]       s1_phase;

    logic [5:0]       ent_luma;
    logic [7:0]       ent_phase;
    logic [3:0]       ent_amp;
    logic [7:0]       color_phase;
    logic [7:0]       burst_phase;
    logic [5:0]       sel_y;
    logic [3:0]       sel_a;
    logic [7:0]       sel_p;

    logic [5:0]       s2_y;
    logic [3:0]       s2_a;
    logic [7:0]       s2_sum;
    logic             s2_valid;

    logic signed [7:0]  s3_sine;
    logic [5:0]         s3_y;
    logic [3:0]         s3_a;
    logic               s3_valid;
    logic signed [12:0] prod;
    logic [7:0]         chroma_next;

    assign ctl_in = {bus.in_valid, bus.blank, bus.burst, bus.sync, bus.pal_flip};

    // Sync zeroing wins over the add so a line can start from a known phase.
    always_ff @(posedge clk) begin
        if (rst)                 acc <= '0;
        else if (bus.phase_sync) acc <= '0;
        else                     acc <= acc + bus.phase_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.lr_addr <= '0;
            s0_ctl      <= '0;
            s0_phase    <= '0;
            s1_ctl      <= '0;
            s1_phase    <= '0;
        end else begin
            bus.lr_addr <= bus.pixel_index;
            s0_ctl      <= ctl_in;
            s0_phase    <= acc[ACC_W-1 -: 8];
            s1_ctl      <= s0_ctl;
            s1_phase    <= s0_phase;
        end
    end

    assign ent_luma    = bus.lr_dout[LUMA_MSB:LUMA_LSB];
    assign ent_phase   = bus.lr_dout[PHASE_MSB:PHASE_LSB];
    assign ent_amp     = bus.lr_dout[AMP_MSB:AMP_LSB];
    assign color_phase = s1_ctl.pal_flip ? (8'd0 - ent_phase) : ent_phase;
    assign burst_phase = s1_ctl.pal_flip ? (8'd0 - BURST_PHASE) : BURST_PHASE;

    always_comb begin
        sel_y = '0;
        sel_a = '0;
        sel_p = '0;
        if (!s1_ctl.sync) begin
            if (s1_ctl.blank && s1_ctl.burst) begin
                sel_a = BURST_AMP;
                sel_p = burst_phase;
            end else if (!s1_ctl.blank) begin
                sel_y = ent_luma;
                sel_a = ent_amp;
                sel_p = color_phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_y     <= '0;
            s2_a     <= '0;
            s2_sum   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_y     <= sel_y;
            s2_a     <= sel_a;
            s2_sum   <= s1_phase + sel_p;
            s2_valid <= s1_ctl.valid;
        end
    end

    chroma_luma_gen_sine_rom u_sine_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (s2_sum),
        .data (s3_sine)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_y     <= '0;
            s3_a     <= '0;
            s3_valid <= 1'b0;
        end else begin
            s3_y     <= s2_y;
            s3_a     <= s2_a;
            s3_valid <= s2_valid;
        end
    end

    // Amplitude is unsigned; the floor shift keeps A=0 at exactly mid-scale.
    assign prod        = $signed({{5{s3_sine[7]}}, s3_sine}) * $signed({9'd0, s3_a});
    assign chroma_next = CHROMA_ZERO + 8'(prod >>> 4);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.luma      <= '0;
            bus.chroma    <= CHROMA_ZERO;
            bus.out_valid <= 1'b0;
        end else begin
            bus.luma      <= s3_y;
            bus.chroma    <= chroma_next;
            bus.out_valid <= s3_valid;
        end
    end

endmodule

// File: tb/tb_chroma_luma_gen.sv
// Scoreboard bench for chroma_luma_gen: a real-arithmetic reference model
// queues expected samples, a monitor pops them whenever out_valid is seen.
module tb_chroma_luma_gen;
    import chroma_luma_gen_pkg::*;

    localparam int         ACC_W = 24;
    localparam logic [7:0] BPH   = 8'd128;
    localparam int         BAMP  = 6;

    typedef struct {
        int stamp;
        int y;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chroma_luma_gen_if #(.ACC_W(ACC_W)) bus ();

    chroma_luma_gen #(
        .ACC_W       (ACC_W),
        .BURST_PHASE (BPH),
        .BURST_AMP   (4'(BAMP))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t             sb[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               cyc   = 0;
    logic [17:0]      ram[16];
    int               sine_tab[256];
    logic [ACC_W-1:0] acc_m = '0;
    logic [ACC_W-1:0] inc_m = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.lr_dout <= ram[bus.lr_addr];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_sample(input int idx, input int blk, input int bst,
                                       input int syn, input int pal, input int nco,
                                       output int y, output int c);
        int luma, ph, amp, a, p;
        logic [17:0] e;
        e    = ram[idx];
        luma = int'(e[17:12]);
        ph   = int'(e[11:4]);
        amp  = int'(e[3:0]);
        p    = 0;
        if (syn != 0) begin
            y = 0; a = 0;
        end else if (blk != 0 && bst != 0) begin
            y = 0; a = BAMP;
            p = (pal != 0) ? (256 - int'(BPH)) % 256 : int'(BPH);
        end else if (blk != 0) begin
            y = 0; a = 0;
        end else begin
            y = luma; a = amp;
            p = (pal != 0) ? (256 - ph) % 256 : ph;
        end
        c = 128 + $rtoi($floor(real'(sine_tab[(nco + p) % 256] * a) / 16.0));
    endfunction

    // Drives one sample at the current negedge, then advances to the next negedge.
    task automatic sample(input int v, input int idx, input int blk, input int bst,
                          input int syn, input int pal, input int psync);
        int y, c, nco;
        bus.in_valid    = 1'(v);
        bus.pixel_index = 4'(idx);
        bus.blank       = 1'(blk);
        bus.burst       = 1'(bst);
        bus.sync        = 1'(syn);
        bus.pal_flip    = 1'(pal);
        bus.phase_sync  = 1'(psync);
        bus.phase_inc   = inc_m;
        nco = int'(acc_m[ACC_W-1 -: 8]);
        if (v != 0) begin
            ref_sample(idx, blk, bst, syn, pal, nco, y, c);
            sb.push_back('{cyc + 1, y, c});
        end
        acc_m = (psync != 0) ? '0 : acc_m + inc_m;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) sample(0, 0, 0, 0, 0, 0, 0);
    endtask

    // One idle cycle first so no valid sample still has its RAM read pending.
    task automatic set_entry(input int idx, input logic [17:0] val);
        idle(1);
        ram[idx] = val;
    endtask

    task automatic do_reset(input int n);
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.phase_sync  = 1'b0;
        bus.pixel_index = 4'd9;
        @(posedge clk);
        sb.delete();
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        acc_m = '0;
        check("rst_luma", int'(bus.luma), 0);
        check("rst_chroma", int'(bus.chroma), 128);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_lr_addr", int'(bus.lr_addr), 0);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("out_valid_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc - e.stamp, 4);
                    check("luma", int'(bus.luma), e.y);
                    check("chroma", int'(bus.chroma), e.c);
                end
            end
            while (sb.size() > 0 && cyc - sb[0].stamp > 4) begin
                check("out_valid_missing", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        real v;
        for (int k = 0; k < 256; k++) begin
            v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 256.0);
            sine_tab[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        end
        for (int i = 0; i < 16; i++) ram[i] = '0;
        bus.in_valid = 1'b0; bus.pixel_index = '0; bus.blank = 1'b0; bus.burst = 1'b0;
        bus.sync = 1'b0; bus.pal_flip = 1'b0; bus.phase_sync = 1'b0; bus.phase_inc = '0;

        @(negedge clk);
        do_reset(3);
        idle(5);
        check("idle_luma", int'(bus.luma), 0);
        check("idle_chroma", int'(bus.chroma), 128);
        check("idle_out_valid", int'(bus.out_valid), 0);
        check("idle_lr_addr", int'(bus.lr_addr), 0);

        // Quarter-turn NCO through a full-amplitude zero-phase colour.
        set_entry(3, {6'd40, 8'd0, 4'd15});
        inc_m = PHASE_INC_NTSC;
        sample(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) sample(1, 3, 0, 0, 0, 0, 0);

        // Zero amplitude must sit at mid-scale whatever the phase.
        set_entry(5, {6'd40, 8'd77, 4'd0});
        inc_m = ACC_W'($urandom);
        for (int i = 0; i < 6; i++) sample(1, 5, 0, 0, 0, 0, 0);

        // PAL V-switch with a frozen NCO at phase 0.
        set_entry(7, {6'd50, 8'd64, 4'd15});
        inc_m = '0;
        sample(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) sample(1, 7, 0, 0, 0, i % 2, 0);

        // Burst, blank-only, sync-over-burst, PAL burst.
        inc_m = PHASE_INC_NTSC;
        sample(0, 0, 0, 0, 0, 0, 1);
        sample(1, 3, 1, 1, 0, 0, 0);
        sample(1, 3, 1, 1, 0, 0, 0);
        sample(1, 3, 1, 1, 1, 0, 0);
        sample(1, 3, 1, 0, 0, 0, 0);
        sample(1, 3, 0, 0, 1, 0, 0);
        sample(1, 3, 1, 1, 0, 1, 0);
        sample(1, 3, 1, 1, 0, 1, 0);

        // Random colours and control mix.
        idle(1);
        for (int i = 0; i < 16; i++) ram[i] = 18'($urandom);
        inc_m = PHASE_INC_PAL;
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 49) inc_m = ACC_W'($urandom);
            sample(($urandom % 4) != 0, $urandom % 16, ($urandom % 4) == 0,
                   $urandom % 2, ($urandom % 8) == 0, $urandom % 2,
                   ($urandom % 32) == 0);
        end

        // Single-cycle reset with the pipeline full, then restart from acc=0.
        for (int i = 0; i < 6; i++) sample(1, $urandom % 16, 0, 0, 0, $urandom % 2, 0);
        do_reset(1);
        for (int i = 0; i < 150; i++) begin
            sample(($urandom % 4) != 0, $urandom % 16, ($urandom % 4) == 0,
                   $urandom % 2, ($urandom % 8) == 0, $urandom % 2,
                   ($urandom % 32) == 0);
        end

        idle(10);
        check("drain_pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
